debug_unit: RTL and testbench
=============================

DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'hA5, first byte of every dump frame.
REQ-002 SHALL have parameter NUM_WORDS, default 9, number of 32-bit pipeline observation words captured per dump.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port probe_words, input, 32*NUM_WORDS, packed pipeline test words, word 0 in bits [31:0]; order is pc, fetched instr, IF/ID instr, read data1, read data2, sign-ext, add result, ALU result, mem read data.
REQ-006 SHALL have port cmd_valid, input, 1, one-cycle strobe marking a received command byte.
REQ-007 SHALL have port cmd_data, input, 8, command byte.
REQ-008 SHALL have port tx_ready, input, 1, byte sink can accept.
REQ-009 SHALL have port tx_valid, output, 1, tx_data valid.
REQ-010 SHALL have port tx_data, output, 8, outgoing byte.
REQ-011 SHALL have port pipe_en, output, 1, pipeline clock enable.
REQ-012 SHALL have port busy, output, 1, high while not in IDLE or RUN.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, STEP, SNAP, DUMP.
REQ-014 IDLE: pipe_en=0; cmd 0x63 'c' -> RUN; 0x73 's' -> STEP; 0x64 'd' -> SNAP; other bytes ignored.
REQ-015 RUN: pipe_en=1 every cycle; cmd 0x68 'h' -> IDLE, pipe_en low from the next cycle; other bytes ignored.
REQ-016 STEP: pipe_en=1 for exactly one cycle, then SNAP.
REQ-017 SNAP: register probe_words into snapshot in one cycle, then DUMP; pipe_en=0.
REQ-018 DUMP: send HEADER_BYTE, then 4*NUM_WORDS bytes, word 0 first, each word MSB byte first; after last byte accepted -> IDLE.
REQ-019 Handshake: byte transfers on cycle with tx_valid && tx_ready; tx_data and tx_valid SHALL stay stable until accepted; tx_valid asserts the cycle after entering DUMP.
REQ-020 Back-to-back transfers SHALL be sustained at one byte per cycle while tx_ready held high.
REQ-021 cmd_valid SHALL be ignored in STEP, SNAP and DUMP (no queuing).
REQ-022 Byte counter SHALL be ceil(log2(4*NUM_WORDS+1)) bits, no wrap past final byte.
REQ-023 busy SHALL be 1 in STEP, SNAP, DUMP.

Reset
REQ-024 Reset SHALL force IDLE, pipe_en=0, tx_valid=0, tx_data=0, busy=0, snapshot and counters to 0.
REQ-025 Reset asserted mid-DUMP SHALL abort the frame; tx_valid drops the next cycle with no further bytes.

Configuration
REQ-026 Macro DEBUG_CYCLE_COUNT_EN: when defined, a 32-bit counter increments on every cycle pipe_en=1, wraps 0xFFFFFFFF->0, resets to 0, and is captured in SNAP and sent as an extra final word (frame 1+4*(NUM_WORDS+1) bytes).
REQ-027 Without DEBUG_CYCLE_COUNT_EN, no counter exists and frame length is 1+4*NUM_WORDS bytes.

Structure
REQ-028 Shared package debug_pkg SHALL hold command codes (CMD_RUN, CMD_STEP, CMD_DUMP, CMD_HALT), state encoding, and default HEADER_BYTE.
REQ-029 Sub-module debug_tx_serializer SHALL own snapshot-to-byte serialization and tx handshake; FSM stays in debug_unit.

Verification
REQ-030 After reset, 'd' with word0=32'h0000_0004, tx_ready=1 -> bytes A5,00,00,00,04,... total 37 (41 with macro), then IDLE.
REQ-031 's' -> pipe_en high exactly one cycle, busy high until last byte accepted, counter (macro) reads 1.
REQ-032 'c' then 'h' 10 cycles later -> pipe_en high 10 consecutive cycles, no bytes transmitted.
REQ-033 tx_ready toggled every other cycle during dump -> tx_data stable while stalled, byte order intact, 37 transfers.
REQ-034 'c' sent during DUMP -> ignored, returns to IDLE with pipe_en=0.
REQ-035 reset after byte 5 of dump -> tx_valid 0 next cycle, outputs at reset values, fresh 'd' yields full frame.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: command bytes, FSM state codes and
// the default dump-frame header byte.
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'
    localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'

    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_STEP = 3'd2;
    localparam logic [2:0] ST_SNAP = 3'd3;
    localparam logic [2:0] ST_DUMP = 3'd4;

endpackage

// File: rtl/debug_tx_serializer.sv
// Holds the captured snapshot and streams it as a header byte followed by
// every word MSB-first over a valid/ready byte interface.
module debug_tx_serializer #(
    parameter int         NWORDS      = 9,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_capture,
    input  logic [32*NWORDS-1:0]  i_words,
    input  logic                  i_start,
    input  logic                  i_tx_ready,
    output logic                  o_tx_valid,
    output logic [7:0]            o_tx_data,
    output logic                  o_done
);

    localparam int NB = 4 * NWORDS;
    localparam int CW = $clog2(NB + 1);

    logic [32*NWORDS-1:0] r_snap;
    logic                 r_valid;
    logic [7:0]           r_data;
    logic [CW-1:0]        r_idx;
    logic                 w_last;

    // idx counts data bytes already queued behind the header: word idx/4, byte idx%4
    function automatic logic [7:0] byte_at(input logic [32*NWORDS-1:0] snap,
                                           input logic [CW-1:0] idx);
        int base;
        base = 32 * int'(idx[CW-1:2]) + 8 * (3 - int'(idx[1:0]));
        return snap[base +: 8];
    endfunction

    assign w_last = (r_idx == CW'(NB));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap  <= '0;
            r_valid <= 1'b0;
            r_data  <= 8'd0;
            r_idx   <= '0;
        end else begin
            if (i_capture)
                r_snap <= i_words;
            if (i_start && !r_valid) begin
                r_valid <= 1'b1;
                r_data  <= HEADER_BYTE;
                r_idx   <= '0;
            end else if (r_valid && i_tx_ready) begin
                if (w_last) begin
                    r_valid <= 1'b0;
                    r_data  <= 8'd0;
                    r_idx   <= '0;
                end else begin
                    r_data <= byte_at(r_snap, r_idx);
                    r_idx  <= r_idx + 1'b1;
                end
            end
        end
    end

    assign o_tx_valid = r_valid;
    assign o_tx_data  = r_data;
    assign o_done     = r_valid && i_tx_ready && w_last;

endmodule

// File: rtl/debug_unit.sv
// Pipeline debug controller: run/halt/single-step the pipeline and dump a
// snapshot of its probe words. Define DEBUG_CYCLE_COUNT_EN to append a cycle counter word.
module debug_unit
    import debug_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER,
    parameter int         NUM_WORDS   = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [32*NUM_WORDS-1:0] probe_words,
    input  logic                    cmd_valid,
    input  logic [7:0]              cmd_data,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    pipe_en,
    output logic                    busy
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       w_pipe_en;
    logic       w_done;

    assign w_pipe_en = (r_state == ST_RUN) || (r_state == ST_STEP);

`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int TX_WORDS = NUM_WORDS + 1;
    logic [31:0]            r_cycle_cnt;
    logic [32*TX_WORDS-1:0] w_snap_words;

    always_ff @(posedge clk) begin
        if (reset)
            r_cycle_cnt <= 32'd0;
        else if (w_pipe_en)
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end

    // The counter rides as the final word of the frame
    assign w_snap_words = {r_cycle_cnt, probe_words};
`else
    localparam int TX_WORDS = NUM_WORDS;
    logic [32*TX_WORDS-1:0] w_snap_words;

    assign w_snap_words = probe_words;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_data == CMD_RUN)
                        w_next = ST_RUN;
                    else if (cmd_data == CMD_STEP)
                        w_next = ST_STEP;
                    else if (cmd_data == CMD_DUMP)
                        w_next = ST_SNAP;
                end
            end
            ST_RUN:  if (cmd_valid && cmd_data == CMD_HALT) w_next = ST_IDLE;
            ST_STEP: w_next = ST_SNAP;
            ST_SNAP: w_next = ST_DUMP;
            ST_DUMP: if (w_done) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    debug_tx_serializer #(
        .NWORDS      (TX_WORDS),
        .HEADER_BYTE (HEADER_BYTE)
    ) u_ser (
        .clk        (clk),
        .reset      (reset),
        .i_capture  (r_state == ST_SNAP),
        .i_words    (w_snap_words),
        .i_start    (r_state == ST_DUMP),
        .i_tx_ready (tx_ready),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .o_done     (w_done)
    );

    assign pipe_en = w_pipe_en;
    assign busy    = (r_state == ST_STEP) || (r_state == ST_SNAP) || (r_state == ST_DUMP);

endmodule

// File: tb/tb_debug_unit.sv
// Directed self-checking bench for debug_unit: reset, dump, step, run/halt,
// stalled dump, command during dump and reset mid-dump.
module tb_debug_unit;

    localparam int NW = 9;
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int FRAME = 1 + 4 * (NW + 1);
`else
    localparam int FRAME = 1 + 4 * NW;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [32*NW-1:0] probe_words;
    logic            cmd_valid;
    logic [7:0]      cmd_data;
    logic            tx_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            pipe_en;
    logic            busy;

    logic [31:0] words [NW];
    logic [31:0] exp_cnt;
    int n_cmp = 0;
    int n_err = 0;

    debug_unit #(.HEADER_BYTE(8'hA5), .NUM_WORDS(NW)) dut (
        .clk         (clk),
        .reset       (reset),
        .probe_words (probe_words),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .pipe_en     (pipe_en),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] w;
        int wi, bi;
        if (k == 0) return 8'hA5;
        wi = (k - 1) / 4;
        bi = (k - 1) % 4;
        w  = (wi < NW) ? words[wi] : exp_cnt;
        return w[31 - 8*bi -: 8];
    endfunction

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Collect a dump frame; optionally stall every other cycle, inject 'c'
    // at a given cycle, or stop after abort_at bytes for a reset test.
    task automatic run_dump(input bit toggle, input int inject_at, input int abort_at);
        int n, cyc, first, last, pe;
        logic [7:0] held;
        bit stalled;
        logic [7:0] got [64];
        n = 0; cyc = 0; first = -1; last = -1; pe = 0; stalled = 0; held = 8'd0;
        while (n < FRAME && cyc < 400) begin
            @(negedge clk);
            if (stalled) begin
                check("hold_valid", 32'(tx_valid), 32'd1);
                check("hold_data", 32'(tx_data), 32'(held));
            end
            if (pipe_en) pe++;
            cmd_valid = (cyc == inject_at);
            cmd_data  = 8'h63;
            tx_ready  = toggle ? cyc[0] : 1'b1;
            if (tx_valid && first < 0) first = cyc;
            if (tx_valid && tx_ready) begin
                got[n] = tx_data;
                n++;
                last = cyc;
            end
            stalled = tx_valid && !tx_ready;
            held    = tx_data;
            cyc++;
            if (abort_at > 0 && n == abort_at) break;
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++)
            check($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_byte(i)));
        if (abort_at > 0) begin
            check("abort_count", 32'(n), 32'(abort_at));
            return;
        end
        check("frame_len", 32'(n), 32'(FRAME));
        check("hdr", 32'(got[0]), 32'hA5);
        if (!toggle) check("back_to_back", 32'(last - first + 1), 32'(FRAME));
        check("pipe_en_in_dump", 32'(pe), 32'd0);
        @(negedge clk);
        check("post_valid", 32'(tx_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_pipe_en", 32'(pipe_en), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe, tv;
        words[0] = 32'h0000_0004;
        for (int i = 1; i < NW; i++)
            words[i] = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i)};
        for (int i = 0; i < NW; i++)
            probe_words[32*i +: 32] = words[i];
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'd0; tx_ready = 1'b1;
        exp_cnt = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_pipe_en", 32'(pipe_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Plain dump after reset
        send_cmd(8'h64);
        check("dump_busy", 32'(busy), 32'd1);
        check("dump_pipe_en", 32'(pipe_en), 32'd0);
        run_dump(1'b0, -1, 0);

        // Single step then dump
        send_cmd(8'h73);
        check("step_pipe_en", 32'(pipe_en), 32'd1);
        check("step_busy", 32'(busy), 32'd1);
        exp_cnt = 32'd1;
        run_dump(1'b0, -1, 0);

        // Run for 10 cycles with a stray 'd' that must be ignored
        pe = 0; tv = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 8'h63;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (pipe_en) pe++;
            if (tx_valid) tv++;
            cmd_valid = (i == 5) || (i == 10);
            cmd_data  = (i == 10) ? 8'h68 : 8'h64;
        end
        cmd_valid = 1'b0;
        check("run_cycles", 32'(pe), 32'd10);
        check("run_no_tx", 32'(tv), 32'd0);
        check("halt_busy", 32'(busy), 32'd0);
        exp_cnt = 32'd11;

        // Dump with tx_ready toggling
        send_cmd(8'h64);
        run_dump(1'b1, -1, 0);

        // 'c' during dump is dropped
        send_cmd(8'h64);
        run_dump(1'b0, 6, 0);
        repeat (3) @(negedge clk);
        check("c_ignored_pipe_en", 32'(pipe_en), 32'd0);

        // Reset after the fifth byte
        send_cmd(8'h64);
        run_dump(1'b0, -1, 5);
        @(negedge clk);
        reset = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_data", 32'(tx_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pipe_en", 32'(pipe_en), 32'd0);
        reset = 1'b0; tx_ready = 1'b1;
        exp_cnt = 32'd0;
        send_cmd(8'h64);
        run_dump(1'b0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
